uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver; next generation of the team's fixed 8N1 receiver.
Runs entirely on clk using a baud-tick enable (no derived clock). Adds:
- configurable data bits, parity and stop bits;
- input synchroniser and false-start rejection;
- framing, parity and overrun detection;
- valid/ready output handshake.
Sits between the rx pad and the packet/command layer.

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, >=4
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 2, rx synchroniser depth, >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  received word, LSB = first bit on line
rx_valid  out  1  rx_data and error flags valid
rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
frame_err  out  1  a stop bit was sampled 0; qualified by rx_valid
parity_err  out  1  parity mismatch; qualified by rx_valid; always 0 when PARITY = 0
overrun  out  1  sticky: a frame completed while rx_valid was high
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rst is synchronous, active-high, on clk.
  - Outputs: rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0.
  - Internal: synchroniser flops = 1, state = IDLE, armed = 0, tick and bit counters = 0.
  - rst mid-frame aborts the frame; no rx_valid is produced for it.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE), integer division.
  - Counter runs 0..DIV-1; one-clk tick pulse when it wraps.
  - Free-running; cleared only by rst.
- Synchroniser: rx passes through SYNC_STAGES flops; rxs = last stage. All decisions use rxs.
- State machine: IDLE, START, DATA, PARITY, STOP. Counters advance only on tick cycles.
  - IDLE:
    - armed is set when rxs = 1 is seen on a tick.
    - If armed and rxs = 0 on a tick: go to START, clear sample count.
  - START:
    - On tick OVERSAMPLE/2 - 1 (mid-bit), sample rxs.
    - rxs = 1: false start; return to IDLE, no outputs change.
    - rxs = 0: go to DATA, clear sample count.
  - DATA:
    - Sample rxs every OVERSAMPLE ticks from the START mid-bit; shift in LSB first.
    - After DATA_BITS samples: go to PARITY if PARITY != 0, else STOP.
  - PARITY:
    - One sample. Odd: data XOR parity bit must be 1. Even: it must be 0.
    - Mismatch latches a pending parity error.
  - STOP:
    - STOP_BITS samples; any sample 0 latches a pending frame error.
    - After the final stop sample: complete the frame, return to IDLE.
    - If the final stop sample was 0, clear armed (break handling).
- Frame completion, on the clk after the final stop mid-sample:
  - rx_valid = 0 at completion: load rx_data, frame_err and parity_err from the pending values; set rx_valid = 1.
  - rx_valid = 1 at completion: drop the new frame; keep rx_data and flags unchanged; set overrun = 1.
  - Errored frames are still delivered, with their flags set.
- Handshake:
  - rx_valid, rx_data and the error flags hold until rx_valid & rx_ready.
  - On the handshake: rx_valid, frame_err, parity_err and overrun clear on the next clk.
  - Handshake and completion in the same cycle: the handshake is taken first, then the new frame loads (rx_valid stays 1, no overrun).
- Break (line held low): produces exactly one frame, rx_data = 0 with frame_err = 1. No new start is detected until rx returns high.
- Latency: rx_valid rises 1 clk after the tick of the final stop mid-sample, plus SYNC_STAGES clks of input delay.

Test Plan:
Bench parameters: CLK_FREQ = 1600000, BAUD_RATE = 10000, OVERSAMPLE = 16, so DIV = 10 and 1 bit = 160 clks. Defaults otherwise unless stated.
1. 8N1 frame 0xA5, rx_ready = 1 -> rx_valid for one clk, rx_data = 0xA5, frame_err = parity_err = overrun = 0.
2. PARITY = 2, frame 0x3C with parity bit 1 -> rx_data = 0x3C, parity_err = 1. Same frame with parity bit 0 -> parity_err = 0.
3. rx low for 40 clks (shorter than half a bit), then high -> no rx_valid; busy returns to 0 within 100 clks.
4. Frame 0x81 with stop bit 0 -> rx_data = 0x81, frame_err = 1. Then rx low for 20 bit times -> exactly one frame, 0x00 with frame_err = 1; nothing further until rx goes high and a valid frame 0x42 arrives, which is received cleanly.
5. rx_ready = 0; send 0x11 then 0x22 -> rx_data = 0x11, overrun = 1. Assert rx_ready for 1 clk -> rx_valid = 0 and overrun = 0.
6. rst pulse after 4 data bits of 0xFF, then frame 0x5A -> all outputs 0 during rst; then rx_data = 0x5A, no errors. Repeat with DATA_BITS = 7, STOP_BITS = 2 -> 0x5A received.

Source files
------------

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with parity, framing and overrun detection
module uart_rx_os #(
    parameter int CLK_FREQ    = 1000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] DIV_LAST  = TW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [TW-1:0]          div_cnt;
    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   rxs;
    logic [CW-1:0]          samp_cnt;
    logic [3:0]             bit_cnt;
    logic                   armed;
    logic [DATA_BITS-1:0]   shreg;
    logic                   fe_pend;
    logic                   pe_pend;
    logic                   sample;
    logic                   frame_end;

    // Free-running baud tick; one pulse per oversample period.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs  = sync_ff[SYNC_STAGES-1];
    assign busy = (state != S_IDLE);

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        frame_end  = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick && armed && !rxs) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (tick && samp_cnt == HALF_LAST) begin
                    sample     = 1'b1;
                    state_next = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && samp_cnt == FULL_LAST) begin
                    sample = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick && samp_cnt == FULL_LAST) begin
                    sample     = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && samp_cnt == FULL_LAST) begin
                    sample = 1'b1;
                    if (bit_cnt == STOP_LAST) begin
                        frame_end  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            samp_cnt <= '0;
            bit_cnt  <= '0;
            armed    <= 1'b0;
            shreg    <= '0;
            fe_pend  <= 1'b0;
            pe_pend  <= 1'b0;
        end else begin
            state <= state_next;
            if (tick) begin
                samp_cnt <= (sample || state == S_IDLE) ? '0 : samp_cnt + 1'b1;
            end
            // Bit counter restarts whenever a sample moves us to a new phase.
            if (sample) begin
                bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
            end
            // A frame ending in a low stop bit is a break: re-arm only after the line idles high.
            if (state == S_IDLE && tick && rxs) begin
                armed <= 1'b1;
            end else if (frame_end && !rxs) begin
                armed <= 1'b0;
            end
            if (sample) begin
                case (state)
                    S_START: begin
                        if (!rxs) begin
                            fe_pend <= 1'b0;
                            pe_pend <= 1'b0;
                        end
                    end
                    S_DATA:   shreg <= {rxs, shreg[DATA_BITS-1:1]};
                    S_PARITY: if ((^shreg ^ rxs) != PAR_ODD) pe_pend <= 1'b1;
                    S_STOP:   if (!rxs) fe_pend <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Handshake is honoured before a same-cycle completion so the new frame can load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
                overrun    <= 1'b0;
            end
            if (frame_end) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    frame_err  <= fe_pend | !rxs;
                    parity_err <= pe_pend;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard bench for uart_rx_os (8N1, 8E1 and 7N2 instances)
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx_line;
    logic [2:0] ready;
    logic [2:0] valid;
    logic [2:0] fe;
    logic [2:0] pe;
    logic [2:0] ovr;
    logic [2:0] busy_o;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [6:0] data2;

    int checks = 0;
    int errors = 0;
    int got[3];
    int vcyc[3];

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    exp_t       m_e;
    logic [7:0] m_d;
    int         m_sz;

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .rx(rx_line[0]), .rx_data(data0), .rx_valid(valid[0]),
        .rx_ready(ready[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0]), .busy(busy_o[0]));

    uart_rx_os #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .PARITY(2)) dut_p (
        .clk(clk), .rst(rst), .rx(rx_line[1]), .rx_data(data1), .rx_valid(valid[1]),
        .rx_ready(ready[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ovr[1]), .busy(busy_o[1]));

    uart_rx_os #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(7), .STOP_BITS(2)) dut_7 (
        .clk(clk), .rst(rst), .rx(rx_line[2]), .rx_data(data2), .rx_valid(valid[2]),
        .rx_ready(ready[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ovr[2]), .busy(busy_o[2]));

    // Scoreboard: every accepted word is matched against the oldest expectation for that instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid[i]) vcyc[i]++;
            if (valid[i] && ready[i]) begin
                got[i]++;
                m_d  = (i == 0) ? data0 : (i == 1) ? data1 : {1'b0, data2};
                m_sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
                checks++;
                if (m_sz == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected inst %0d got data %h expected no frame", i, m_d);
                end else begin
                    case (i)
                        0:       m_e = q0.pop_front();
                        1:       m_e = q1.pop_front();
                        default: m_e = q2.pop_front();
                    endcase
                    checks += 3;
                    if (m_d !== m_e.data) begin
                        errors++;
                        $display("FAIL rx_data inst %0d got %h expected %h", i, m_d, m_e.data);
                    end
                    if (fe[i] !== m_e.fe) begin
                        errors++;
                        $display("FAIL frame_err inst %0d data %h got %b expected %b", i, m_e.data, fe[i], m_e.fe);
                    end
                    if (pe[i] !== m_e.pe) begin
                        errors++;
                        $display("FAIL parity_err inst %0d data %h got %b expected %b", i, m_e.data, pe[i], m_e.pe);
                    end
                end
            end
        end
    end

    task automatic push(input int inst, input logic [7:0] d, input logic f, input logic p);
        exp_t e;
        e.data = d;
        e.fe   = f;
        e.pe   = p;
        case (inst)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic hold(input int inst, input logic b, input int nbits);
        rx_line[inst] = b;
        repeat (BIT_CLKS * nbits) @(posedge clk);
        #1;
    endtask

    // par < 0 means no parity bit on the line.
    task automatic send(input int inst, input logic [8:0] d, input int nbits, input int par,
                        input logic stop_v, input int nstop);
        hold(inst, 1'b0, 1);
        for (int i = 0; i < nbits; i++) hold(inst, d[i], 1);
        if (par >= 0) hold(inst, par[0], 1);
        for (int i = 0; i < nstop; i++) hold(inst, stop_v, 1);
        rx_line[inst] = 1'b1;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        rx_line = 3'b111;
        ready   = 3'b111;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if ({valid, fe, pe, ovr, busy_o} !== 15'h0) begin
            errors++;
            $display("FAIL reset_flags got %h expected 0", {valid, fe, pe, ovr, busy_o});
        end
        if ({data0, data1, data2} !== 23'h0) begin
            errors++;
            $display("FAIL reset_data got %h expected 0", {data0, data1, data2});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int g = got[0];
        int v = vcyc[0];
        push(0, 8'hA5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, -1, 1'b1, 1);
        hold(0, 1'b1, 1);
        checks += 3;
        if (got[0] - g !== 1) begin
            errors++;
            $display("FAIL basic_count got %0d expected 1", got[0] - g);
        end
        if (vcyc[0] - v !== 1) begin
            errors++;
            $display("FAIL basic_valid_width got %0d expected 1", vcyc[0] - v);
        end
        if (ovr[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_overrun got %b expected 0", ovr[0]);
        end
    endtask

    task automatic test_parity;
        int g = got[1];
        push(1, 8'h3C, 1'b0, 1'b1);
        send(1, 9'h03C, 8, 1, 1'b1, 1);
        push(1, 8'h3C, 1'b0, 1'b0);
        send(1, 9'h03C, 8, 0, 1'b1, 1);
        hold(1, 1'b1, 1);
        checks++;
        if (got[1] - g !== 2) begin
            errors++;
            $display("FAIL parity_count got %0d expected 2", got[1] - g);
        end
    endtask

    task automatic test_false_start;
        int g = got[0];
        rx_line[0] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy got %b expected 1", busy_o[0]);
        end
        repeat (20) @(posedge clk);
        #1 rx_line[0] = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle got %b expected 0", busy_o[0]);
        end
        if (got[0] - g !== 0) begin
            errors++;
            $display("FAIL glitch_count got %0d expected 0", got[0] - g);
        end
        hold(0, 1'b1, 1);
    endtask

    task automatic test_break;
        int g = got[0];
        push(0, 8'h81, 1'b1, 1'b0);
        send(0, 9'h081, 8, -1, 1'b0, 1);
        hold(0, 1'b1, 2);
        push(0, 8'h00, 1'b1, 1'b0);
        hold(0, 1'b0, 20);
        @(negedge clk);
        checks += 2;
        if (busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL break_idle got %b expected 0", busy_o[0]);
        end
        if (got[0] - g !== 2) begin
            errors++;
            $display("FAIL break_count got %0d expected 2", got[0] - g);
        end
        hold(0, 1'b1, 2);
        push(0, 8'h42, 1'b0, 1'b0);
        send(0, 9'h042, 8, -1, 1'b1, 1);
        hold(0, 1'b1, 1);
        checks++;
        if (got[0] - g !== 3) begin
            errors++;
            $display("FAIL break_recover_count got %0d expected 3", got[0] - g);
        end
    endtask

    task automatic test_overrun;
        ready[0] = 1'b0;
        push(0, 8'h11, 1'b0, 1'b0);
        send(0, 9'h011, 8, -1, 1'b1, 1);
        send(0, 9'h022, 8, -1, 1'b1, 1);
        hold(0, 1'b1, 1);
        @(negedge clk);
        checks += 3;
        if (valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_valid got %b expected 1", valid[0]);
        end
        if (data0 !== 8'h11) begin
            errors++;
            $display("FAIL overrun_data got %h expected 11", data0);
        end
        if (ovr[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag got %b expected 1", ovr[0]);
        end
        @(posedge clk);
        #1 ready[0] = 1'b1;
        @(posedge clk);
        #1 ready[0] = 1'b0;
        @(negedge clk);
        checks += 2;
        if (valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_valid_clear got %b expected 0", valid[0]);
        end
        if (ovr[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got %b expected 0", ovr[0]);
        end
        ready[0] = 1'b1;
    endtask

    task automatic test_reset_abort(input int inst, input int nbits, input int nstop);
        hold(inst, 1'b0, 1);
        hold(inst, 1'b1, 4);
        @(negedge clk);
        checks++;
        if (busy_o[inst] !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_pre inst %0d got %b expected 1", inst, busy_o[inst]);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        rx_line[inst] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if ({valid[inst], fe[inst], pe[inst], ovr[inst], busy_o[inst]} !== 5'b0) begin
            errors++;
            $display("FAIL abort_flags inst %0d got %b expected 00000", inst,
                     {valid[inst], fe[inst], pe[inst], ovr[inst], busy_o[inst]});
        end
        if ({data0, data2} !== 15'h0) begin
            errors++;
            $display("FAIL abort_data got %h expected 0", {data0, data2});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        hold(inst, 1'b1, 1);
        push(inst, 8'h5A, 1'b0, 1'b0);
        send(inst, 9'h05A, nbits, -1, 1'b1, nstop);
        hold(inst, 1'b1, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_break();
        test_overrun();
        test_reset_abort(0, 8, 1);
        test_reset_abort(2, 7, 2);
        checks += 3;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL pending_inst0 got %0d expected 0", q0.size());
        end
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL pending_inst1 got %0d expected 0", q1.size());
        end
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL pending_inst2 got %0d expected 0", q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
